// File: rtl/master_addr_pkg.sv
// ----------------------------------------------------------------------------
// master_addr_pkg
// Shared definitions for the master address path. The write-side packer and
// the read-side drain both use this package.
//   - Field widths and LSB offsets of the 44-bit packed FIFO word {id, addr, len}
//   - Constant AXI size/burst values driven on every AR/AW beat
//   - addr_word_t: packed view of one FIFO word
//   - crosses_4k(): true when a burst runs past the 4KB page that holds its start
// ----------------------------------------------------------------------------
package master_addr_pkg;

    localparam int ID_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int LEN_WIDTH  = 8;
    localparam int FIFO_DW    = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH;

    localparam int LEN_LSB  = 0;
    localparam int ADDR_LSB = LEN_LSB + LEN_WIDTH;
    localparam int ID_LSB   = ADDR_LSB + ADDR_WIDTH;

    localparam logic [2:0] AXSIZE  = 3'd2;
    localparam logic [1:0] AXBURST = 2'b01;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
    } addr_word_t;

    // Page offset plus burst byte count; ending exactly on the page boundary is legal.
    function automatic logic crosses_4k(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [LEN_WIDTH-1:0]  len);
        logic [13:0] w_end;
        w_end = {2'b00, addr[11:0]} + ({5'b00000, {1'b0, len} + 9'd1} << AXSIZE);
        return (w_end > 14'd4096);
    endfunction

endpackage

// File: rtl/master_addr_fifo_drain_buf.sv
// ----------------------------------------------------------------------------
// addr_prefetch_buf
// Two-entry in-order buffer sitting between the FIFO read port and the AXI
// address channel. Head/tail are 1-bit pointers; occupancy is kept explicitly.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   i_push           write i_push_data at the tail (ignored when full and not popping)
//   i_push_data      word to store
//   i_pop            retire the head entry (ignored when empty)
//   o_occ            entries held, 0..2
//   o_head_data      oldest entry (all zero after reset)
// ----------------------------------------------------------------------------
module addr_prefetch_buf
    import master_addr_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [1:0]    o_occ,
    output logic [DW-1:0] o_head_data
);

    logic [DW-1:0] r_mem [2];
    logic          r_head;
    logic          r_tail;
    logic [1:0]    r_occ;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign w_pop_ok  = i_pop & (r_occ != 2'd0);
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok = i_push & ((r_occ != 2'd2) | w_pop_ok);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_tail] <= i_push_data;
                r_tail        <= ~r_tail;
            end
            if (w_pop_ok) begin
                r_head <= ~r_head;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ       = r_occ;
    assign o_head_data = r_mem[r_head];

endmodule

// File: rtl/master_addr_fifo_drain.sv
// ----------------------------------------------------------------------------
// master_addr_fifo_drain
// Read-side consumer of the master address FIFO. Pops packed {id, addr, len}
// words and presents them on an AXI4 AR/AW channel. A 2-entry prefetch buffer
// hides the FIFO's 1-cycle read latency so one beat per cycle is sustained
// while m_axready stays high.
// Ports:
//   clk, rstn        single clock, synchronous active-low reset
//   fifo_rd_en       FIFO pop request (data returns one cycle later)
//   fifo_rd_data     FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_empty    FIFO empty flag
//   m_axid/addr/len  head-entry payload
//   m_axsize/burst   constant size / INCR burst
//   m_axvalid/ready  AXI address handshake
//   idle             buffer empty and no read in flight
//   err_4k           sticky 4KB-crossing flag
// Build option: define MASTER_ADDR_4K_CHK_EN to build the 4KB-crossing check;
// otherwise err_4k is tied low.
// ----------------------------------------------------------------------------
module master_addr_fifo_drain
    import master_addr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    output logic                  fifo_rd_en,
    input  logic [FIFO_DW-1:0]    fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic [ID_WIDTH-1:0]   m_axid,
    output logic [ADDR_WIDTH-1:0] m_axaddr,
    output logic [LEN_WIDTH-1:0]  m_axlen,
    output logic [2:0]            m_axsize,
    output logic [1:0]            m_axburst,
    output logic                  m_axvalid,
    input  logic                  m_axready,
    output logic                  idle,
    output logic                  err_4k
);

    logic               r_pend;
    logic [1:0]         w_occ;
    logic [FIFO_DW-1:0] w_head_data;
    logic               w_pop;
    logic [2:0]         w_committed;

    assign m_axvalid = (w_occ != 2'd0);
    assign w_pop     = m_axvalid & m_axready;

    // Slots already spoken for after this edge: held entries plus the word in
    // flight, minus the one leaving now. A new read is only issued when that
    // leaves room, which makes buffer overflow impossible.
    assign w_committed = {1'b0, w_occ} + {2'b00, r_pend} - {2'b00, w_pop};
    assign fifo_rd_en  = rstn & ~fifo_rd_empty & (w_committed < 3'd2);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= fifo_rd_en;
        end
    end

    addr_prefetch_buf #(
        .DW (FIFO_DW)
    ) u_buf (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (r_pend),
        .i_push_data (fifo_rd_data),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head_data (w_head_data)
    );

    assign m_axid    = w_head_data[ID_LSB   +: ID_WIDTH];
    assign m_axaddr  = w_head_data[ADDR_LSB +: ADDR_WIDTH];
    assign m_axlen   = w_head_data[LEN_LSB  +: LEN_WIDTH];
    assign m_axsize  = AXSIZE;
    assign m_axburst = AXBURST;
    assign idle      = (w_occ == 2'd0) & ~r_pend;

`ifdef MASTER_ADDR_4K_CHK_EN
    logic r_err_4k;

    // Flag only; the offending transaction is still issued unchanged.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_err_4k <= 1'b0;
        end else if (w_pop && crosses_4k(m_axaddr, m_axlen)) begin
            r_err_4k <= 1'b1;
        end
    end

    assign err_4k = r_err_4k;
`else
    assign err_4k = 1'b0;
`endif

    // A word arriving while full with nothing leaving would be lost.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
        !((w_occ == 2'd2) && r_pend && !w_pop));

endmodule

// File: tb/tb_master_addr_fifo_drain.sv
// ----------------------------------------------------------------------------
// tb_master_addr_fifo_drain
// Drives master_addr_fifo_drain from a behavioural FIFO (queue with one-cycle
// read latency) and checks the AXI side with a scoreboard: every word written
// into the FIFO is expected, in order, on the address channel.
// ----------------------------------------------------------------------------
module tb_master_addr_fifo_drain;
    import master_addr_pkg::*;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  fifo_rd_en;
    logic [FIFO_DW-1:0]    fifo_rd_data = '0;
    logic                  fifo_rd_empty = 1'b1;
    logic [ID_WIDTH-1:0]   m_axid;
    logic [ADDR_WIDTH-1:0] m_axaddr;
    logic [LEN_WIDTH-1:0]  m_axlen;
    logic [2:0]            m_axsize;
    logic [1:0]            m_axburst;
    logic                  m_axvalid;
    logic                  m_axready = 1'b0;
    logic                  idle;
    logic                  err_4k;

`ifdef MASTER_ADDR_4K_CHK_EN
    localparam logic EXP_CROSS = 1'b1;
`else
    localparam logic EXP_CROSS = 1'b0;
`endif

    master_addr_fifo_drain dut (
        .clk           (clk),
        .rstn          (rstn),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m_axid        (m_axid),
        .m_axaddr      (m_axaddr),
        .m_axlen       (m_axlen),
        .m_axsize      (m_axsize),
        .m_axburst     (m_axburst),
        .m_axvalid     (m_axvalid),
        .m_axready     (m_axready),
        .idle          (idle),
        .err_4k        (err_4k)
    );

    initial forever #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    logic [FIFO_DW-1:0] fifo_q[$];
    logic [FIFO_DW-1:0] sb_q[$];
    int               hs_cyc_q[$];
    int               rdy_rand = 0;
    logic             rdy_fixed = 1'b0;
    int               gap_pct = 0;
    logic             exp_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [FIFO_DW-1:0] pack(input int id, input logic [31:0] addr, input int len);
        logic [3:0] w_id;
        logic [7:0] w_len;
        w_id  = id[3:0];
        w_len = len[7:0];
        return {w_id, addr, w_len};
    endfunction

    // A burst of (len+1) 4-byte beats starting at the page offset must end at or before 4096.
    function automatic logic crosses(input logic [FIFO_DW-1:0] w);
        int off;
        int bytes;
        off   = int'(w[19:8]);
        bytes = (int'(w[7:0]) + 1) * 4;
        return (off + bytes > 4096);
    endfunction

    task automatic push_word(input logic [FIFO_DW-1:0] w);
        fifo_q.push_back(w);
        sb_q.push_back(w);
    endtask

    // FIFO model + ready driver. Inputs change at the falling edge; the read
    // request seen just before the rising edge decides what is returned next cycle.
    initial begin
        bit rd_issued = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_issued && rstn && fifo_q.size() != 0) begin
                fifo_rd_data = fifo_q.pop_front();
            end
            m_axready     = (rdy_rand != 0) ? ($urandom_range(0, 1) == 1) : rdy_fixed;
            fifo_rd_empty = (fifo_q.size() == 0) || ($urandom_range(0, 99) < gap_pct);
            #1;
            rd_issued = fifo_rd_en;
        end
    end

    // Monitor: compares the AXI side against the scoreboard every cycle.
    initial begin
        bit               prev_rstn = 1'b0;
        bit               held = 1'b0;
        logic [FIFO_DW-1:0] exp_w;
        forever begin
            @(negedge clk);
            #2;
            if (!prev_rstn) begin
                exp_err = 1'b0;
                held    = 1'b0;
                chk("rst_valid", m_axvalid, 0);
                chk("rst_idle", idle, 1);
                chk("rst_payload", {m_axid, m_axaddr, m_axlen}, 0);
            end
            chk("err_4k", err_4k, exp_err);
            if (!rstn) begin
                chk("rst_rd_en", fifo_rd_en, 0);
            end else begin
                if (held) chk("valid_hold", m_axvalid, 1);
                held = 1'b0;
                if (m_axvalid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h required=none", {m_axid, m_axaddr, m_axlen});
                    end else begin
                        chk("head_payload", {m_axid, m_axaddr, m_axlen}, sb_q[0]);
                        if (m_axready) begin
                            exp_w = sb_q.pop_front();
                            chk("axsize", m_axsize, 2);
                            chk("axburst", m_axburst, 1);
                            hs_cyc_q.push_back(cyc);
`ifdef MASTER_ADDR_4K_CHK_EN
                            if (crosses(exp_w)) exp_err = 1'b1;
`endif
                            $display("beat %0d id=%0h addr=%08h len=%0d", hs_cyc_q.size(), m_axid, m_axaddr, m_axlen);
                        end else begin
                            held = 1'b1;
                        end
                    end
                end
            end
            prev_rstn = rstn;
        end
    end

    task automatic assert_reset();
        @(posedge clk);
        #3;
        rstn = 1'b0;
        fifo_q.delete();
        sb_q.delete();
    endtask

    task automatic release_reset(input int n);
        repeat (n) @(posedge clk);
        #3;
        rstn = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || !idle) && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d_left required=0", sb_q.size());
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #3;
    endtask

    initial begin
        int cnt;
        int first_hs;
        logic [31:0] raddr;

        // 1: reset with a loaded FIFO, then check read / valid latency
        rdy_fixed = 1'b0;
        assert_reset();
        for (int i = 0; i < 4; i++) push_word(pack(i, 32'h100 + 32'(i), 1));
        release_reset(3);
        next_cycle();
        chk("t1_rd_en_c1", fifo_rd_en, 1);
        chk("t1_valid_c1", m_axvalid, 0);
        next_cycle();
        chk("t1_valid_c2", m_axvalid, 0);
        next_cycle();
        chk("t1_valid_c3", m_axvalid, 1);
        rdy_fixed = 1'b1;
        wait_drain(200);

        // 2: streaming with ready held high
        hs_cyc_q.delete();
        for (int i = 0; i < 512; i++) push_word(pack(i, 32'(i * 64), 3));
        wait_drain(2000);
        chk("t2_count", hs_cyc_q.size(), 512);
        if (hs_cyc_q.size() > 0) begin
            first_hs = hs_cyc_q[0];
            chk("t2_back_to_back", hs_cyc_q[hs_cyc_q.size()-1] - first_hs, 511);
        end

        // 3: backpressure against a full FIFO
        rdy_fixed = 1'b0;
        for (int i = 0; i < 10; i++) push_word(pack(i + 5, 32'h2000 + 32'(i * 16), i));
        cnt = 0;
        repeat (20) begin
            next_cycle();
            if (fifo_rd_en) cnt++;
        end
        chk("t3_reads_issued", cnt, 2);
        chk("t3_rd_en_low", fifo_rd_en, 0);
        chk("t3_valid_held", m_axvalid, 1);
        rdy_fixed = 1'b1;
        wait_drain(200);

        // 4: random ready and FIFO empty gaps
        hs_cyc_q.delete();
        rdy_rand = 1;
        gap_pct  = 30;
        for (int i = 0; i < 1000; i++) begin
            raddr = $urandom;
            push_word(pack($urandom_range(0, 15), raddr, $urandom_range(0, 255)));
        end
        wait_drain(20000);
        chk("t4_count", hs_cyc_q.size(), 1000);
        rdy_rand  = 0;
        gap_pct   = 0;
        rdy_fixed = 1'b1;

        // 5: reset while streaming with a read in flight
        for (int i = 0; i < 20; i++) push_word(pack(i, 32'h3000 + 32'(i * 4), 0));
        repeat (6) next_cycle();
        assert_reset();
        for (int i = 0; i < 4; i++) push_word(pack(15 - i, 32'hA000_0000 + 32'(i * 32), 2));
        release_reset(1);
        wait_drain(200);

        // 6: 4KB boundary check
        assert_reset();
        release_reset(1);
        push_word(pack(1, 32'h0000_0FF0, 3));
        wait_drain(100);
        repeat (2) next_cycle();
        chk("t6_ends_on_page", err_4k, 0);
        push_word(pack(2, 32'h0000_0FF4, 3));
        wait_drain(100);
        repeat (2) next_cycle();
        chk("t6_crosses_page", err_4k, EXP_CROSS);
        repeat (5) next_cycle();
        chk("t6_sticky", err_4k, EXP_CROSS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
